// File: rtl/odometer_scan_ctrl.sv
// Scan sequencer for the RO odometer decoder: settles, measures and captures every sensor pair,
// then streams per-sensor results. Optional threshold flagging is compiled in with ODO_THRESH_EN.
module odometer_scan_ctrl #(
    parameter int NO_CDIR      = 8,
    parameter int MUX_SEL_SIZE = $clog2(NO_CDIR),
    parameter int SETTLE_CYC   = 4,
    parameter int CAPTURE_DLY  = 3,
    parameter int MEAS_TIMEOUT = 256,
    parameter int CNT_W        = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    stress_en,
    input  logic                    start,
    input  logic                    abort,
    output logic [1:0]              dec_mode,
    output logic [MUX_SEL_SIZE-1:0] dec_r_sel,
    output logic [MUX_SEL_SIZE-1:0] dec_s_sel,
    input  logic [CNT_W-1:0]        dec_r_freq,
    input  logic [CNT_W-1:0]        dec_s_freq,
    input  logic                    dec_valid,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [MUX_SEL_SIZE-1:0] res_idx,
    output logic [CNT_W-1:0]        res_r_freq,
    output logic [CNT_W-1:0]        res_s_freq,
    output logic [CNT_W-1:0]        res_diff,
    output logic                    res_err,
    output logic                    busy,
    output logic                    done
`ifdef ODO_THRESH_EN
    ,
    input  logic [CNT_W-1:0]        thresh,
    output logic                    res_aged,
    output logic                    aged_any
`endif
);

    localparam int TMR_MAX0 = (SETTLE_CYC > CAPTURE_DLY) ? SETTLE_CYC : CAPTURE_DLY;
    localparam int TMR_MAX  = (MEAS_TIMEOUT > TMR_MAX0) ? MEAS_TIMEOUT : TMR_MAX0;
    localparam int TMR_W    = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0]        SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0]        MEAS_LAST   = TMR_W'(MEAS_TIMEOUT - 1);
    localparam logic [TMR_W-1:0]        DLY_LAST    = TMR_W'(CAPTURE_DLY - 1);
    localparam logic [MUX_SEL_SIZE-1:0] IDX_LAST    = MUX_SEL_SIZE'(NO_CDIR - 1);

    localparam logic [1:0] MODE_OFF    = 2'd0;
    localparam logic [1:0] MODE_STRESS = 2'd1;
    localparam logic [1:0] MODE_MEAS   = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MEASURE,
        ST_WAIT,
        ST_CAPTURE,
        ST_OUTPUT,
        ST_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [MUX_SEL_SIZE-1:0] idx_q, idx_d;
    logic [TMR_W-1:0]        tmr_q, tmr_d;
    logic                    err_q, err_d;
    logic [1:0]              dec_mode_q, dec_mode_d;
    logic                    res_valid_q, res_valid_d;
    logic [MUX_SEL_SIZE-1:0] res_idx_q, res_idx_d;
    logic [CNT_W-1:0]        res_r_q, res_r_d;
    logic [CNT_W-1:0]        res_s_q, res_s_d;
    logic [CNT_W-1:0]        res_diff_q, res_diff_d;
    logic                    res_err_q, res_err_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [CNT_W-1:0]        diff_w;
`ifdef ODO_THRESH_EN
    logic                    res_aged_q, res_aged_d;
    logic                    aged_any_q, aged_any_d;
    logic                    aged_w;
`endif

    // A timed-out measurement reports its raw counts but never a delta.
    assign diff_w = (!err_q && (dec_r_freq >= dec_s_freq)) ? (dec_r_freq - dec_s_freq) : '0;
`ifdef ODO_THRESH_EN
    assign aged_w = (diff_w >= thresh) && !err_q;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        tmr_d       = tmr_q;
        err_d       = err_q;
        res_valid_d = res_valid_q;
        res_idx_d   = res_idx_q;
        res_r_d     = res_r_q;
        res_s_d     = res_s_q;
        res_diff_d  = res_diff_q;
        res_err_d   = res_err_q;
`ifdef ODO_THRESH_EN
        res_aged_d  = res_aged_q;
        aged_any_d  = aged_any_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d = ST_SETTLE;
                    idx_d   = '0;
                    tmr_d   = '0;
                    err_d   = 1'b0;
`ifdef ODO_THRESH_EN
                    aged_any_d = 1'b0;
`endif
                end
            end
            ST_SETTLE: begin
                if (tmr_q == SETTLE_LAST) begin
                    state_d = ST_MEASURE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_MEASURE: begin
                // dec_valid is checked first so it wins over a coincident timeout.
                if (dec_valid) begin
                    state_d = (CAPTURE_DLY == 0) ? ST_CAPTURE : ST_WAIT;
                    tmr_d   = '0;
                end else if (tmr_q == MEAS_LAST) begin
                    state_d = ST_CAPTURE;
                    err_d   = 1'b1;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_WAIT: begin
                if (tmr_q == DLY_LAST) begin
                    state_d = ST_CAPTURE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_CAPTURE: begin
                res_idx_d   = idx_q;
                res_r_d     = dec_r_freq;
                res_s_d     = dec_s_freq;
                res_diff_d  = diff_w;
                res_err_d   = err_q;
                res_valid_d = 1'b1;
`ifdef ODO_THRESH_EN
                res_aged_d  = aged_w;
                aged_any_d  = aged_any_q | aged_w;
`endif
                state_d     = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SETTLE;
                        idx_d   = idx_q + 1'b1;
                        tmr_d   = '0;
                        err_d   = 1'b0;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase

        if (abort && (state_q != ST_IDLE)) begin
            state_d     = ST_IDLE;
            idx_d       = '0;
            tmr_d       = '0;
            err_d       = 1'b0;
            res_valid_d = 1'b0;
        end

        // Outputs are registered from the next state so they line up with the state they describe.
        case (state_d)
            ST_IDLE:             dec_mode_d = stress_en ? MODE_STRESS : MODE_OFF;
            ST_MEASURE, ST_WAIT: dec_mode_d = MODE_MEAS;
            default:             dec_mode_d = MODE_OFF;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            tmr_q       <= '0;
            err_q       <= 1'b0;
            dec_mode_q  <= MODE_OFF;
            res_valid_q <= 1'b0;
            res_idx_q   <= '0;
            res_r_q     <= '0;
            res_s_q     <= '0;
            res_diff_q  <= '0;
            res_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef ODO_THRESH_EN
            res_aged_q  <= 1'b0;
            aged_any_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tmr_q       <= tmr_d;
            err_q       <= err_d;
            dec_mode_q  <= dec_mode_d;
            res_valid_q <= res_valid_d;
            res_idx_q   <= res_idx_d;
            res_r_q     <= res_r_d;
            res_s_q     <= res_s_d;
            res_diff_q  <= res_diff_d;
            res_err_q   <= res_err_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef ODO_THRESH_EN
            res_aged_q  <= res_aged_d;
            aged_any_q  <= aged_any_d;
`endif
        end
    end

    assign dec_mode   = dec_mode_q;
    assign dec_r_sel  = idx_q;
    assign dec_s_sel  = idx_q;
    assign res_valid  = res_valid_q;
    assign res_idx    = res_idx_q;
    assign res_r_freq = res_r_q;
    assign res_s_freq = res_s_q;
    assign res_diff   = res_diff_q;
    assign res_err    = res_err_q;
    assign busy       = busy_q;
    assign done       = done_q;
`ifdef ODO_THRESH_EN
    assign res_aged   = res_aged_q;
    assign aged_any   = aged_any_q;
`endif

endmodule

// File: doc/odometer_scan_ctrl.md
Name: odometer_scan_ctrl

Overview:
- Controller that sequences the RO odometer sensor/decoder across all CDIR sensor pairs.
- Drives decoder mode and mux selects, and times settle and measure windows.
- Captures reference/stressed counts per sensor and computes the aging delta (ref minus stressed).
- Streams per-sensor results to the host-side register block over a valid/ready interface.
- Between scans it holds the decoder in stress mode so stressed ROs keep aging.

Parameters:
- NO_CDIR, 8, number of sensor pairs scanned.
- MUX_SEL_SIZE, $clog2(NO_CDIR), width of the sensor index and mux selects.
- SETTLE_CYC, 4, cycles decoder is held in mode 0 before each measurement (≥1).
- CAPTURE_DLY, 3, cycles waited after dec_valid before sampling counts; lets async RO-domain counts settle.
- MEAS_TIMEOUT, 256, max cycles in mode 2 waiting for dec_valid.
- CNT_W, 32, width of frequency counts and delta.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- stress_en  in  1  1: decoder in mode 1 (stress) while idle; 0: mode 0 (off)
- start  in  1  single-cycle pulse, begin a full scan
- abort  in  1  terminate scan, return to IDLE
- dec_mode  out  2  decoder mode (0 off, 1 stress, 2 measure)
- dec_r_sel  out  MUX_SEL_SIZE  reference RO mux select
- dec_s_sel  out  MUX_SEL_SIZE  stressed RO mux select
- dec_r_freq  in  CNT_W  decoder reference count
- dec_s_freq  in  CNT_W  decoder stressed count
- dec_valid  in  1  decoder measurement complete
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_idx  out  MUX_SEL_SIZE  sensor index of result
- res_r_freq  out  CNT_W  captured reference count
- res_s_freq  out  CNT_W  captured stressed count
- res_diff  out  CNT_W  saturated delta
- res_err  out  1  measurement timed out
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse, scan complete

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE, dec_mode=0, selects=0, sensor index=0.
  - All res_* outputs 0; busy=0, done=0.
- IDLE:
  - dec_mode = stress_en ? 1 : 0, registered, so effective one cycle after change.
  - start=1 → SETTLE with idx=0, busy=1.
- SETTLE:
  - dec_mode=0; dec_r_sel=dec_s_sel=idx.
  - Stay exactly SETTLE_CYC cycles, then → MEASURE.
- MEASURE:
  - dec_mode=2, selects=idx; timer counts cycles in state.
  - dec_valid=1 → WAIT.
  - Timer reaches MEAS_TIMEOUT with no dec_valid → CAPTURE with err=1.
  - If dec_valid and timeout occur in the same cycle, dec_valid wins.
- WAIT:
  - dec_mode=2; hold CAPTURE_DLY cycles, then → CAPTURE.
- CAPTURE (1 cycle):
  - Register res_r_freq, res_s_freq, res_idx, res_err.
  - res_diff = r ≥ s ? r − s : 0, unsigned CNT_W, no wrap.
  - On timeout, the raw counts are still captured and res_diff=0.
  - dec_mode=0; next cycle → OUTPUT with res_valid=1.
- OUTPUT:
  - dec_mode=0; res_* held stable while res_valid=1 and res_ready=0.
  - Transfer occurs on a cycle with res_valid & res_ready; res_valid drops the next cycle.
  - After transfer: if idx=NO_CDIR−1 → DONE, else idx+1 → SETTLE.
  - res_ready may be held high permanently; results then issue back-to-back at SETTLE+measure spacing.
- DONE (1 cycle):
  - done=1, busy=0 from the next cycle, idx=0 → IDLE.
- start while busy=1: ignored.
- abort (any non-IDLE state):
  - Next cycle: IDLE, res_valid=0, idx=0, busy=0, done not pulsed.
  - A result presented in the same cycle as abort counts as transferred if res_ready=1.
  - abort takes priority over start when both occur in IDLE.
- Reset mid-operation: immediate return to reset values; no partial result emitted.

Optional Feature:
- Macro ODO_THRESH_EN enables aging-threshold flagging.
- With it:
  - Additional input thresh[CNT_W−1:0] and outputs res_aged (1) and aged_any (1).
  - res_aged is registered in CAPTURE as (res_diff ≥ thresh) & ~err.
  - aged_any is a sticky OR over all results of the current scan; cleared on start; valid when done pulses.
- Without it: these ports and logic are absent; all other behaviour is identical.

Test Plan:
- Single scan, NO_CDIR=8, res_ready=1, decoder model returns r=1000, s=830 per sensor →
  - 8 results, idx 0..7, res_diff=170, res_err=0, done pulses once;
  - dec_mode sequence per sensor: 0 for 4 cycles, 2 until dec_valid+3 cycles, then 0.
- Negative delta: r=500, s=620 → res_diff=0 (saturated), res_r_freq=500, res_s_freq=620.
- Timeout: dec_valid held 0 for sensor 3 → after 256 cycles in mode 2, res_idx=3, res_err=1, res_diff=0; scan continues to sensor 4.
- Backpressure: res_ready=0 for 10 cycles at sensor 2 → res_* stable, dec_mode=0, no advance; ready=1 → idx 3 SETTLE next cycle.
- Abort/reset: abort asserted during MEASURE of sensor 5 → next cycle IDLE, dec_mode=1 (stress_en=1), no done. Repeat with rst_n low mid-WAIT → all outputs 0 asynchronously.
- ODO_THRESH_EN: thresh=150, diffs {170,100,…} → res_aged=1 for idx0, 0 for idx1; aged_any=1 at done; restart clears aged_any.
